// File: rtl/firebird7_in_gate1_ijtag_seq_pkg.sv
// Shared types, sizing constants and chain-length helper for the IJTAG SIB scan sequencer.
package firebird7_in_gate1_ijtag_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    SHIFT,
    UPDATE,
    SETTLE,
    VERIFY,
    DONE
  } seq_state_e;

  localparam int MAX_SIB        = 16;
  localparam int DEF_NUM_SIB    = 4;
  localparam int DEF_SEG_LEN    = 3;
  localparam int DEF_SETTLE_CYC = 2;
  localparam int MAX_LEN        = DEF_NUM_SIB * (1 + DEF_SEG_LEN);
  localparam int CNT_W          = $clog2(MAX_LEN + 1);

  function automatic int max_len(input int num_sib, input int seg_len);
    return num_sib * (1 + seg_len);
  endfunction

  // Every SIB bit is always in the chain; an open SIB adds its child segment.
  function automatic int chain_len(input logic [MAX_SIB-1:0] mask, input int num_sib,
                                   input int seg_len);
    int len;
    len = num_sib;
    for (int i = 0; i < MAX_SIB; i++) begin
      if ((i < num_sib) && mask[i]) len = len + seg_len;
    end
    return len;
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_ijtag_seq_stream.sv
// Maps a shift-cycle index onto the scan stream: SIB bits carry the mask, child bits are 0.
module firebird7_in_gate1_ijtag_seq_stream #(
  parameter int NUM_SIB = 4,
  parameter int SEG_LEN = 3,
  parameter int CW      = 4
) (
  input  logic [NUM_SIB-1:0] mask_i,
  input  logic [NUM_SIB-1:0] open_i,
  input  logic [CW-1:0]      k_i,
  output logic               bit_o,
  output logic               sib_pos_o
);

  // Walk from the tail SIB toward si; stream index 0 lands on the last SIB.
  always_comb begin
    int pos;
    bit_o     = 1'b0;
    sib_pos_o = 1'b0;
    pos       = 0;
    for (int i = NUM_SIB - 1; i >= 0; i--) begin
      if (int'(k_i) == pos) begin
        bit_o     = mask_i[i];
        sib_pos_o = 1'b1;
      end
      pos = pos + 1;
      if (open_i[i]) pos = pos + SEG_LEN;
    end
  end

endmodule

// File: rtl/firebird7_in_gate1_ijtag_sib_sequencer.sv
// Capture-Shift-Update scan master for a flat SIB array.
// Optional readback pass after SETTLE enabled by FIREBIRD7_IJTAG_SEQ_VERIFY_EN.
module firebird7_in_gate1_ijtag_sib_sequencer
  import firebird7_in_gate1_ijtag_seq_pkg::*;
#(
  parameter int NUM_SIB    = DEF_NUM_SIB,
  parameter int SEG_LEN    = DEF_SEG_LEN,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic               ijtag_tck,
  input  logic               ijtag_reset,
  input  logic               req_valid,
  input  logic [NUM_SIB-1:0] req_mask,
  output logic               req_ready,
  output logic               done,
  output logic               busy,
  output logic [NUM_SIB-1:0] cur_mask,
  output logic               verify_err,
  output logic               ijtag_sel,
  output logic               ijtag_ce,
  output logic               ijtag_se,
  output logic               ijtag_ue,
  output logic               ijtag_si,
  input  logic               ijtag_so
);

  localparam int LEN_MAX = max_len(NUM_SIB, SEG_LEN);
  localparam int CW      = $clog2(LEN_MAX + 1);
  localparam int SW      = $clog2(SETTLE_CYC + 1);
  localparam int CNTW    = (CW > SW) ? CW : SW;

  seq_state_e         state_q, state_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [CNTW-1:0]    len_q, len_d;
  logic [NUM_SIB-1:0] mask_q, mask_d;
  logic [NUM_SIB-1:0] cur_mask_q, cur_mask_d;
  logic               err_q, err_d;
  logic [NUM_SIB-1:0] stream_open;
  logic               stream_bit;
  logic               stream_sib_pos;

`ifdef FIREBIRD7_IJTAG_SEQ_VERIFY_EN
  // Readback walks the chain as the new open state shaped it.
  assign stream_open = (state_q == VERIFY) ? mask_q : cur_mask_q;
  assign verify_err  = err_q;
`else
  logic unused_stream;
  assign unused_stream = ^{ijtag_so, stream_sib_pos};
  assign stream_open   = cur_mask_q;
  assign verify_err    = 1'b0;
`endif

  firebird7_in_gate1_ijtag_seq_stream #(
    .NUM_SIB(NUM_SIB),
    .SEG_LEN(SEG_LEN),
    .CW     (CW)
  ) u_stream (
    .mask_i   (mask_q),
    .open_i   (stream_open),
    .k_i      (cnt_q[CW-1:0]),
    .bit_o    (stream_bit),
    .sib_pos_o(stream_sib_pos)
  );

  assign cur_mask = cur_mask_q;

  always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      mask_q     <= '0;
      cur_mask_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      mask_q     <= mask_d;
      cur_mask_q <= cur_mask_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    mask_d     = mask_q;
    cur_mask_d = cur_mask_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    ijtag_sel  = 1'b0;
    ijtag_ce   = 1'b0;
    ijtag_se   = 1'b0;
    ijtag_ue   = 1'b0;
    ijtag_si   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          // Chain length is fixed by the open state the array has right now.
          mask_d  = req_mask;
          len_d   = CNTW'(chain_len(MAX_SIB'(cur_mask_q), NUM_SIB, SEG_LEN));
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        ijtag_sel = 1'b1;
        ijtag_ce  = 1'b1;
        cnt_d     = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        ijtag_sel = 1'b1;
        ijtag_se  = 1'b1;
        ijtag_si  = stream_bit;
        if (cnt_q == len_q - CNTW'(1)) begin
          cnt_d   = '0;
          state_d = UPDATE;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      UPDATE: begin
        ijtag_sel = 1'b1;
        ijtag_ue  = 1'b1;
        cnt_d     = '0;
        state_d   = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == CNTW'(SETTLE_CYC - 1)) begin
          cnt_d = '0;
`ifdef FIREBIRD7_IJTAG_SEQ_VERIFY_EN
          len_d   = CNTW'(chain_len(MAX_SIB'(mask_q), NUM_SIB, SEG_LEN));
          state_d = VERIFY;
`else
          state_d = DONE;
`endif
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
`ifdef FIREBIRD7_IJTAG_SEQ_VERIFY_EN
      VERIFY: begin
        ijtag_sel = 1'b1;
        ijtag_se  = 1'b1;
        ijtag_si  = stream_bit;
        if (stream_sib_pos && (ijtag_so != stream_bit)) err_d = 1'b1;
        if (cnt_q == len_q - CNTW'(1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
`endif
      DONE: begin
        done = 1'b1;
        if (!err_q) cur_mask_d = mask_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_firebird7_in_gate1_ijtag_sib_sequencer.sv
// Scoreboard bench for the SIB sequencer: stimulus queues expected passes, a negedge monitor checks them.
// Exercises the readback path too when FIREBIRD7_IJTAG_SEQ_VERIFY_EN is defined.
module tb_firebird7_in_gate1_ijtag_sib_sequencer;
  import firebird7_in_gate1_ijtag_seq_pkg::*;

  typedef struct {
    logic [3:0]  mask;
    logic [3:0]  expCur;
    int          len;
    logic [15:0] si;
    int          lenV;
    logic [15:0] soV;
    logic        expErr;
  } vec_t;

  logic       tck = 1'b0;
  logic       rst = 1'b1;
  logic       reqValid = 1'b0;
  logic [3:0] reqMask = 4'b0000;
  logic       so = 1'b0;
  logic       reqReady, done, busy, verifyErr, sel, ce, se, ue, si;
  logic [3:0] curMask;

  int   testsRun = 0;
  int   testsFailed = 0;
  int   doneCnt = 0;
  int   acceptCnt = 0;
  bit   abandon = 1'b0;
  vec_t expQ[$];
  vec_t cur;
  vec_t vecs[12];
  int   numVecs;

  logic [CNT_W-1:0] shiftIdx = '0;
  logic [CNT_W-1:0] verIdx = '0;
  int   busyCnt = 0;
  bit   seenUe = 1'b0;
  bit   pendingCur = 1'b0;
  logic [3:0] curExp = 4'b0000;

  firebird7_in_gate1_ijtag_sib_sequencer #(
    .NUM_SIB(4),
    .SEG_LEN(3),
    .SETTLE_CYC(2)
  ) dut (
    .ijtag_tck  (tck),
    .ijtag_reset(rst),
    .req_valid  (reqValid),
    .req_mask   (reqMask),
    .req_ready  (reqReady),
    .done       (done),
    .busy       (busy),
    .cur_mask   (curMask),
    .verify_err (verifyErr),
    .ijtag_sel  (sel),
    .ijtag_ce   (ce),
    .ijtag_se   (se),
    .ijtag_ue   (ue),
    .ijtag_si   (si),
    .ijtag_so   (so)
  );

  always #5 tck = ~tck;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s: event not expected or never seen", name);
  endtask

  task automatic waitDone(input int target, input string name);
    int budget;
    budget = 4 * MAX_LEN + 40;
    while (doneCnt < target && budget > 0) begin
      @(posedge tck);
      #1;
      budget--;
    end
    if (doneCnt < target) reportFail({name, "Timeout"});
  endtask

  task automatic applyStimulus(input vec_t v);
    int target;
    target = doneCnt + 1;
    expQ.push_back(v);
    reqMask  = v.mask;
    reqValid = 1'b1;
    @(posedge tck);
    #1;
    reqValid = 1'b0;
    waitDone(target, "pass");
  endtask

  // Monitor: protocol rules every cycle, shift data against the queued pass, latency and results at done.
  always @(negedge tck) begin
    if (rst) begin
      busyCnt    = 0;
      shiftIdx   = '0;
      verIdx     = '0;
      seenUe     = 1'b0;
      pendingCur = 1'b0;
      so         = 1'b0;
    end else begin
      checkOutput("protocol",
                  {31'd0, ((32'(ce) + 32'(se) + 32'(ue)) <= 32'd1) && (sel == (ce | se | ue))
                          && (se || !si) && (reqReady == !busy)}, 32'd1);
      if (reqValid && reqReady) acceptCnt++;
      if (busy) busyCnt++;
      if (ue) begin
        if (!abandon && expQ.size() > 0) checkOutput("shiftLen", 32'(shiftIdx), expQ[0].len);
        seenUe = 1'b1;
      end
      if (se && !seenUe && !abandon) begin
        if (expQ.size() == 0) reportFail("unexpectedShift");
        else begin
          cur = expQ[0];
          checkOutput($sformatf("si[%0d]", shiftIdx), {31'd0, si},
                      {31'd0, cur.si[cur.len - 1 - int'(shiftIdx)]});
        end
        shiftIdx++;
      end
`ifdef FIREBIRD7_IJTAG_SEQ_VERIFY_EN
      if (se && seenUe && expQ.size() > 0) begin
        cur = expQ[0];
        so  = cur.soV[cur.lenV - 1 - int'(verIdx)];
        verIdx++;
      end else begin
        so = 1'b0;
      end
`endif
      if (done) begin
        if (expQ.size() == 0) reportFail("unexpectedDone");
        else begin
          cur = expQ.pop_front();
`ifdef FIREBIRD7_IJTAG_SEQ_VERIFY_EN
          checkOutput("passCycles", busyCnt, cur.len + 5 + cur.lenV);
`else
          checkOutput("passCycles", busyCnt, cur.len + 5);
`endif
          checkOutput("verifyErr", {31'd0, verifyErr}, {31'd0, cur.expErr});
          curExp     = cur.expCur;
          pendingCur = 1'b1;
        end
        doneCnt++;
        busyCnt  = 0;
        shiftIdx = '0;
        verIdx   = '0;
        seenUe   = 1'b0;
      end else if (pendingCur) begin
        checkOutput("curMask", {28'd0, curMask}, {28'd0, curExp});
        pendingCur = 1'b0;
      end
    end
  end

  initial begin
    int base;
    int target;
    int doneBefore;
    // mask, expCur, len, si (cycle 0 = MSB of len), lenV, readback stream, expErr
    vecs[0] = '{mask: 4'b0101, expCur: 4'b0101, len: 4,  si: 16'b0101,
                lenV: 10, soV: 16'b0100001000, expErr: 1'b0};
    vecs[1] = '{mask: 4'b0011, expCur: 4'b0011, len: 10, si: 16'b0000011000,
                lenV: 10, soV: 16'b0010001000, expErr: 1'b0};
    vecs[2] = '{mask: 4'b0011, expCur: 4'b0011, len: 10, si: 16'b0010001000,
                lenV: 10, soV: 16'b0010001000, expErr: 1'b0};
    vecs[3] = '{mask: 4'b1000, expCur: 4'b1000, len: 4,  si: 16'b1000,
                lenV: 7,  soV: 16'b1000000, expErr: 1'b0};
    vecs[4] = '{mask: 4'b0110, expCur: 4'b0110, len: 7,  si: 16'b0000110,
                lenV: 10, soV: 16'b0100010000, expErr: 1'b0};
    vecs[5] = '{mask: 4'b0110, expCur: 4'b0110, len: 10, si: 16'b0100010000,
                lenV: 10, soV: 16'b0100010000, expErr: 1'b0};
    vecs[6] = '{mask: 4'b1111, expCur: 4'b1111, len: 10, si: 16'b1100010001,
                lenV: 16, soV: 16'b1000100010001000, expErr: 1'b0};
    vecs[7] = '{mask: 4'b0000, expCur: 4'b0000, len: 16, si: 16'b0,
                lenV: 4,  soV: 16'b0000, expErr: 1'b0};
    vecs[8] = '{mask: 4'b0010, expCur: 4'b0000, len: 4,  si: 16'b0010,
                lenV: 7,  soV: 16'b0000000, expErr: 1'b1};
    vecs[9] = '{mask: 4'b0010, expCur: 4'b0010, len: 4,  si: 16'b0010,
                lenV: 7,  soV: 16'b0010000, expErr: 1'b0};
`ifdef FIREBIRD7_IJTAG_SEQ_VERIFY_EN
    numVecs = 10;
`else
    numVecs = 8;
`endif

    repeat (3) @(posedge tck);
    #1;
    checkOutput("resetState", {23'd0, sel, ce, se, ue, si, done, busy, verifyErr, reqReady, curMask},
                {23'd0, 9'b000000001, 4'b0000});
    rst = 1'b0;
    @(posedge tck);
    #1;

    for (int i = 0; i < 3; i++) applyStimulus(vecs[i]);

    // Abandon a pass partway through SHIFT with reset.
    abandon  = 1'b1;
    reqMask  = 4'b1100;
    reqValid = 1'b1;
    @(posedge tck);
    #1;
    reqValid = 1'b0;
    repeat (3) @(posedge tck);
    #1;
    checkOutput("midShiftSe", {31'd0, se}, 32'd1);
    doneBefore = doneCnt;
    rst = 1'b1;
    #1;
    checkOutput("resetMidPass", {23'd0, sel, ce, se, ue, si, done, busy, verifyErr, reqReady, curMask},
                {23'd0, 9'b000000001, 4'b0000});
    repeat (2) @(posedge tck);
    #1;
    rst     = 1'b0;
    abandon = 1'b0;
    repeat (3) @(posedge tck);
    #1;
    checkOutput("noDoneAfterReset", doneCnt, doneBefore);

    applyStimulus(vecs[3]);

    // Request held high across a whole pass: one accept per pass, re-accept right after DONE.
    base   = acceptCnt;
    target = doneCnt + 2;
    expQ.push_back(vecs[4]);
    expQ.push_back(vecs[5]);
    reqMask  = 4'b0110;
    reqValid = 1'b1;
    waitDone(doneCnt + 1, "heldFirst");
    checkOutput("readyAfterDone", {31'd0, reqReady}, 32'd1);
    @(posedge tck);
    #1;
    reqValid = 1'b0;
    waitDone(target, "heldSecond");
    checkOutput("acceptsHeld", acceptCnt - base, 32'd2);

    for (int i = 6; i < numVecs; i++) applyStimulus(vecs[i]);

    repeat (3) @(posedge tck);
    #1;
    checkOutput("queueDrained", expQ.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
